// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory access unit between the fetch port and the load/store port.
// Optional MEM_ARB_ROUND_ROBIN_EN: ties go to the port not served last (default: ls always wins ties).
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int WATCHDOG_CYCLES = 1024,
    parameter int WD_WIDTH        = 11
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic        if_resp_fault,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_is_write,
    input  logic        ls_is_unsigned,
    input  logic [1:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_resp_valid,
    output logic        ls_resp_fault,
    output logic [31:0] resp_rdata,
    output logic        timeout,
    output logic        mem_available,
    output logic        mem_is_write,
    output logic        mem_is_unsigned,
    output logic [1:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_busy,
    input  logic        mem_fault
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [WD_WIDTH-1:0] WD_LIMIT  = WD_WIDTH'(WATCHDOG_CYCLES);
    localparam logic [WD_WIDTH-1:0] WD_ONE    = WD_WIDTH'(1);
    localparam logic                WD_ENABLE = (WATCHDOG_CYCLES != 0);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_owner_ls;
    logic                r_mem_available;
    logic                r_is_write;
    logic                r_is_unsigned;
    logic [1:0]          r_op;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_fault;
    logic [WD_WIDTH-1:0] r_wd_cnt;
    logic [31:0]         r_rdata;
    logic                r_timeout;
    logic                r_if_resp_valid;
    logic                r_ls_resp_valid;
    logic                r_if_resp_fault;
    logic                r_ls_resp_fault;

    logic w_can_grant;
    logic w_grant_ls;
    logic w_grant_if;
    logic w_grant_edge;
    logic w_wd_expired;
    logic w_timeout_hit;
    logic w_enter_release;
    logic w_fault_final;

    // Arbitration; the owner register doubles as last-owner for round-robin ties.
    always_comb begin
        w_can_grant = reset_n && (r_state == ST_IDLE) && !mem_busy;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w_grant_ls  = ls_req_valid && (!if_req_valid || !r_owner_ls);
`else
        w_grant_ls  = ls_req_valid;
`endif
        w_grant_if   = if_req_valid && !w_grant_ls;
        ls_req_ready = w_can_grant && w_grant_ls;
        if_req_ready = w_can_grant && w_grant_if;
        w_grant_edge = ls_req_ready || if_req_ready;
    end

    // Next-state logic, including watchdog abort out of WAIT.
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_hit = 1'b0;
        w_wd_expired  = WD_ENABLE && (r_wd_cnt == WD_LIMIT);
        case (r_state)
            ST_IDLE: begin
                if (w_grant_edge) w_state_nxt = ST_ISSUE;
                else              w_state_nxt = ST_IDLE;
            end
            ST_ISSUE: begin
                if (mem_busy) w_state_nxt = ST_WAIT;
                else          w_state_nxt = ST_ISSUE;
            end
            ST_WAIT: begin
                if (!mem_busy) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_wd_expired) begin
                    w_state_nxt   = ST_RELEASE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        w_enter_release = (r_state == ST_WAIT) && (w_state_nxt == ST_RELEASE);
        w_fault_final   = r_fault || w_timeout_hit;
    end

    // State, owner and the memory-unit availability handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_owner_ls      <= 1'b0;
            r_mem_available <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_edge) begin
                r_owner_ls      <= w_grant_ls;
                r_mem_available <= 1'b1;
            end else if (w_enter_release) begin
                r_mem_available <= 1'b0;
            end
        end
    end

    // Request latch; fetch is always a plain word read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_write    <= 1'b0;
            r_is_unsigned <= 1'b0;
            r_op          <= 2'b00;
            r_addr        <= 32'h0000_0000;
            r_wdata       <= 32'h0000_0000;
        end else if (w_grant_edge) begin
            if (w_grant_ls) begin
                r_is_write    <= ls_is_write;
                r_is_unsigned <= ls_is_unsigned;
                r_op          <= ls_op;
                r_addr        <= ls_addr;
                r_wdata       <= ls_wdata;
            end else begin
                r_is_write    <= 1'b0;
                r_is_unsigned <= 1'b0;
                r_op          <= 2'b10;
                r_addr        <= if_addr;
                r_wdata       <= 32'h0000_0000;
            end
        end
    end

    // Fault capture, watchdog, read data and the one-cycle response pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fault         <= 1'b0;
            r_wd_cnt        <= '0;
            r_rdata         <= 32'h0000_0000;
            r_timeout       <= 1'b0;
            r_if_resp_valid <= 1'b0;
            r_ls_resp_valid <= 1'b0;
            r_if_resp_fault <= 1'b0;
            r_ls_resp_fault <= 1'b0;
        end else begin
            if ((r_state == ST_ISSUE) && mem_busy) begin
                r_fault  <= mem_fault;
                r_wd_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wd_cnt <= r_wd_cnt + WD_ONE;
            end
            if (w_timeout_hit) begin
                r_fault   <= 1'b1;
                r_timeout <= 1'b1;
            end
            if (w_enter_release && !w_timeout_hit && !r_is_write) begin
                r_rdata <= mem_out;
            end
            r_if_resp_valid <= w_enter_release && !r_owner_ls;
            r_ls_resp_valid <= w_enter_release && r_owner_ls;
            r_if_resp_fault <= w_enter_release && !r_owner_ls && w_fault_final;
            r_ls_resp_fault <= w_enter_release && r_owner_ls && w_fault_final;
        end
    end

    assign mem_available   = r_mem_available;
    assign mem_is_write    = r_is_write;
    assign mem_is_unsigned = r_is_unsigned;
    assign mem_op          = r_op;
    assign mem_addr        = r_addr;
    assign mem_in          = r_wdata;
    assign resp_rdata      = r_rdata;
    assign timeout         = r_timeout;
    assign if_resp_valid   = r_if_resp_valid;
    assign ls_resp_valid   = r_ls_resp_valid;
    assign if_resp_fault   = r_if_resp_fault;
    assign ls_resp_fault   = r_ls_resp_fault;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table, watchdog/reset sequences and
// randomized transactions against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int WD = 8;

    typedef struct {
        logic        ifv, lsv, wr, uns;
        logic [1:0]  op;
        logic [31:0] ifa, lsa, wd, data;
        int          lat;
        logic        exp_ls, exp_fault;
        logic [31:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready, if_resp_valid, if_resp_fault;
    logic [31:0] if_addr = 32'h0;
    logic        ls_req_valid = 1'b0, ls_req_ready, ls_is_write = 1'b0, ls_is_unsigned = 1'b0;
    logic [1:0]  ls_op = 2'b00;
    logic [31:0] ls_addr = 32'h0, ls_wdata = 32'h0;
    logic        ls_resp_valid, ls_resp_fault, timeout;
    logic [31:0] resp_rdata;
    logic        mem_available, mem_is_write, mem_is_unsigned, mem_busy, mem_fault;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr, mem_in, mem_out;

    mem_arbiter #(.WATCHDOG_CYCLES(WD), .WD_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_fault(if_resp_fault),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_is_write(ls_is_write),
        .ls_is_unsigned(ls_is_unsigned), .ls_op(ls_op), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_resp_valid(ls_resp_valid), .ls_resp_fault(ls_resp_fault),
        .resp_rdata(resp_rdata), .timeout(timeout),
        .mem_available(mem_available), .mem_is_write(mem_is_write),
        .mem_is_unsigned(mem_is_unsigned), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_in(mem_in), .mem_out(mem_out), .mem_busy(mem_busy), .mem_fault(mem_fault)
    );

    // Memory unit model: busy from start until lat cycles elapse, faults on misalignment.
    logic        m_started = 1'b0;
    int          m_cnt = 0;
    int          m_lat = 1;
    logic        hold_busy = 1'b0;
    logic [31:0] m_data = 32'h0;

    function automatic logic misaligned(input logic [1:0] op, input logic [31:0] addr);
        case (op)
            2'b00:   return 1'b0;
            2'b01:   return addr[0];
            2'b10:   return (addr[1:0] != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    assign mem_busy  = hold_busy || (mem_available && (!m_started || (m_cnt != 0)));
    assign mem_fault = mem_available && !m_started && misaligned(mem_op, mem_addr);
    assign mem_out   = m_data;

    always @(posedge clk) begin
        if (!mem_available) begin
            m_started <= 1'b0;
            m_cnt     <= 0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_cnt     <= m_lat - 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    // Reference model state
    int          checks = 0, errors = 0;
    logic [31:0] g_rdata = 32'h0;
    logic        g_timeout = 1'b0;
    logic        g_last_ls = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic pick_ls(input logic ifv, input logic lsv);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return lsv && (!ifv || !g_last_ls);
`else
        return lsv;
`endif
    endfunction

    function automatic vec_t mk(input logic ifv, lsv, wr, uns, input logic [1:0] op,
                                input logic [31:0] ifa, lsa, wd, data, input int lat,
                                input logic exp_ls, exp_fault, input logic [31:0] exp_rd);
        vec_t v;
        v.ifv = ifv; v.lsv = lsv; v.wr = wr; v.uns = uns; v.op = op;
        v.ifa = ifa; v.lsa = lsa; v.wd = wd; v.data = data; v.lat = lat;
        v.exp_ls = exp_ls; v.exp_fault = exp_fault; v.exp_rd = exp_rd;
        return v;
    endfunction

    // One full transaction: grant, latched request stable, response timing and contents.
    task automatic run_txn(input vec_t v, input logic hold, input string tag);
        int n, resp_at;
        logic to_hit, early_ok, avail_ok, latch_ok;
        logic [1:0] e_op;
        logic [31:0] e_addr, e_in;
        logic e_wr, e_uns;
        @(negedge clk);
        m_lat = v.lat; m_data = v.data;
        if_req_valid = v.ifv; if_addr = v.ifa;
        ls_req_valid = v.lsv; ls_is_write = v.wr; ls_is_unsigned = v.uns;
        ls_op = v.op; ls_addr = v.lsa; ls_wdata = v.wd;
        #1;
        n = 0;
        while (!(if_req_ready || ls_req_ready) && n < 30) begin
            @(negedge clk); #1; n++;
        end
        chk32({tag, "/grant_wait"}, 32'(n), 32'd0);
        if (n >= 30) begin
            if_req_valid = 1'b0; ls_req_valid = 1'b0;
            return;
        end
        chk1({tag, "/ls_ready"}, ls_req_ready, v.exp_ls);
        chk1({tag, "/if_ready"}, if_req_ready, !v.exp_ls);
        to_hit  = (v.lat >= WD + 2);
        resp_at = (to_hit ? WD + 1 : v.lat) + 2;
        e_op    = v.exp_ls ? v.op : 2'b10;
        e_addr  = v.exp_ls ? v.lsa : v.ifa;
        e_in    = v.exp_ls ? v.wd : 32'h0;
        e_wr    = v.exp_ls ? v.wr : 1'b0;
        e_uns   = v.exp_ls ? v.uns : 1'b0;
        early_ok = 1'b1; avail_ok = 1'b1; latch_ok = 1'b1;
        for (int k = 1; k <= resp_at; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if_req_valid = 1'b0; ls_req_valid = 1'b0;
                if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom;
                ls_op = 2'($urandom_range(0, 3)); ls_is_write = !v.wr; ls_is_unsigned = !v.uns;
                if (hold) hold_busy = 1'b1;
            end
            if (k < resp_at) begin
                if (if_resp_valid || ls_resp_valid) early_ok = 1'b0;
                if (mem_available !== 1'b1) avail_ok = 1'b0;
                if ({mem_op, mem_addr, mem_in, mem_is_write, mem_is_unsigned} !==
                    {e_op, e_addr, e_in, e_wr, e_uns}) latch_ok = 1'b0;
            end
        end
        g_last_ls = v.exp_ls;
        g_timeout = g_timeout || to_hit;
        g_rdata   = v.exp_rd;
        chk1({tag, "/no_early_resp"}, early_ok, 1'b1);
        chk1({tag, "/avail_high"}, avail_ok, 1'b1);
        chk1({tag, "/latch_stable"}, latch_ok, 1'b1);
        chk1({tag, "/avail_release"}, mem_available, 1'b0);
        chk1({tag, "/ls_resp_valid"}, ls_resp_valid, v.exp_ls);
        chk1({tag, "/if_resp_valid"}, if_resp_valid, !v.exp_ls);
        chk1({tag, "/ls_resp_fault"}, ls_resp_fault, v.exp_ls && v.exp_fault);
        chk1({tag, "/if_resp_fault"}, if_resp_fault, !v.exp_ls && v.exp_fault);
        chk32({tag, "/rdata"}, resp_rdata, v.exp_rd);
        chk1({tag, "/timeout"}, timeout, g_timeout);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got no completion expected $finish before 1ms");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vt[12];
        vec_t rv;
        logic tie_odd;
        int sel;
        logic [1:0] e_op;
        logic [31:0] e_addr;
        logic is_rd;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie_odd = 1'b0;
`else
        tie_odd = 1'b1;
`endif
        vt[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'hDEADBEEF);
        vt[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 32'h0, 32'h203, 32'h1234, 32'h1111_1111, 1, 1'b1, 1'b1, 32'hDEADBEEF);
        vt[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h3, 32'h0, 32'hFFFFFF80, 1, 1'b1, 1'b0, 32'hFFFFFF80);
        vt[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h5, 32'h0, 32'h0000_0080, 2, 1'b1, 1'b0, 32'h0000_0080);
        vt[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 32'h8, 32'h0, 32'h1122_3344, 3, 1'b1, 1'b0, 32'h1122_3344);
        vt[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h102, 32'h0, 32'h0, 32'hAAAA_5555, 1, 1'b0, 1'b1, 32'hAAAA_5555);
        vt[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h40, 32'h80, 32'h0, 32'h6000_0006, 1, 1'b1, 1'b0, 32'h6000_0006);
        vt[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h40, 32'h80, 32'h0, 32'h7000_0007, 2, tie_odd, 1'b0, 32'h7000_0007);
        vt[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h40, 32'h80, 32'h0, 32'h8000_0008, 1, 1'b1, 1'b0, 32'h8000_0008);
        vt[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h40, 32'h80, 32'h0, 32'h9000_0009, 3, tie_odd, 1'b0, 32'h9000_0009);
        vt[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 32'h10, 32'hCAFEF00D, 32'h5555_5555, 2, 1'b1, 1'b0, 32'h9000_0009);
        vt[11] = mk(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h21, 32'h0, 32'h0000_BEEF, 1, 1'b1, 1'b1, 32'h0000_BEEF);

        // Reset state
        repeat (2) @(negedge clk);
        chk1("reset/mem_available", mem_available, 1'b0);
        chk1("reset/resp_valid", if_resp_valid | ls_resp_valid, 1'b0);
        chk1("reset/timeout", timeout, 1'b0);
        chk32("reset/rdata", resp_rdata, 32'h0);
        chk32("reset/mem_addr", mem_addr, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_txn(vt[i], 1'b0, $sformatf("vec%0d", i));

        // Watchdog: memory stays busy, aborted 10 cycles after ISSUE, then grant held off
        rv = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h200, 32'h0, 32'h0, 32'h7777_7777, 100, 1'b0, 1'b1, g_rdata);
        run_txn(rv, 1'b1, "wdog");
        ls_req_valid = 1'b1; ls_is_write = 1'b0; ls_op = 2'b10; ls_addr = 32'h44; m_lat = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk1($sformatf("wdog/blocked%0d", i), ls_req_ready, 1'b0);
        end
        @(negedge clk); hold_busy = 1'b0; #1;
        chk1("wdog/grant_on_idle", ls_req_ready, 1'b1);
        ls_req_valid = 1'b0;

        // Reset in the middle of WAIT while the memory unit is busy
        @(negedge clk);
        ls_req_valid = 1'b1; ls_is_write = 1'b0; ls_op = 2'b10; ls_addr = 32'h48; m_lat = 5;
        #1 chk1("rst/grant", ls_req_ready, 1'b1);
        @(negedge clk); ls_req_valid = 1'b0; hold_busy = 1'b1;
        @(negedge clk); @(negedge clk);
        chk1("rst/in_wait", mem_available, 1'b1);
        reset_n = 1'b0; #1;
        chk1("rst/mem_available", mem_available, 1'b0);
        chk32("rst/mem_addr", mem_addr, 32'h0);
        chk1("rst/timeout", timeout, 1'b0);
        chk32("rst/rdata", resp_rdata, 32'h0);
        chk1("rst/resp_valid", if_resp_valid | ls_resp_valid, 1'b0);
        g_rdata = 32'h0; g_timeout = 1'b0; g_last_ls = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; ls_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk1($sformatf("rst/blocked%0d", i), ls_req_ready, 1'b0);
            @(negedge clk);
        end
        hold_busy = 1'b0;
        #1 chk1("rst/grant_after_busy", ls_req_ready, 1'b1);
        ls_req_valid = 1'b0;

        // Randomized transactions against the reference model
        for (int t = 0; t < 150; t++) begin
            sel    = $urandom_range(0, 2);
            rv.ifv = (sel == 0) || (sel == 2);
            rv.lsv = (sel == 1) || (sel == 2);
            rv.wr  = 1'($urandom_range(0, 1));
            rv.uns = 1'($urandom_range(0, 1));
            rv.op  = 2'($urandom_range(0, 2));
            rv.ifa = $urandom; rv.lsa = $urandom; rv.wd = $urandom; rv.data = $urandom;
            if ($urandom_range(0, 1) == 1) rv.ifa[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) rv.lsa[1:0] = 2'b00;
            rv.lat       = $urandom_range(1, 12);
            rv.exp_ls    = pick_ls(rv.ifv, rv.lsv);
            e_op         = rv.exp_ls ? rv.op : 2'b10;
            e_addr       = rv.exp_ls ? rv.lsa : rv.ifa;
            rv.exp_fault = (rv.lat >= WD + 2) || misaligned(e_op, e_addr);
            is_rd        = rv.exp_ls ? !rv.wr : 1'b1;
            rv.exp_rd    = (is_rd && (rv.lat < WD + 2)) ? rv.data : g_rdata;
            run_txn(rv, 1'b0, $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
